// File: rtl/reg_file.sv
// Architectural register file with per-register rename alias for a reorder-buffer core.
// Optional REG_COMMIT_BYPASS_EN forwards a same-cycle commit onto the source read ports.
module reg_file (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback_signal,
    input  logic        res_rdy_2reg,
    input  logic [31:0] res_2reg,
    input  logic [4:0]  regidx_2regfile,
    input  logic [4:0]  reg_alias,
    input  logic        rename_en,
    input  logic [4:0]  rename_rd,
    input  logic [4:0]  rename_alias,
    input  logic [4:0]  rs1_idx,
    input  logic [4:0]  rs2_idx,
    output logic [4:0]  Qi,
    output logic [4:0]  Qj,
    output logic [31:0] Vi,
    output logic [31:0] Vj
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned IDX_W = 5;
    localparam int unsigned NREG  = 32;

`ifdef REG_COMMIT_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    logic [XLEN-1:0]  vals    [NREG];
    logic [IDX_W-1:0] alias_q [NREG];

    logic commit_act_c;
    logic rename_act_c;
    logic bypass_ok_c;

    assign commit_act_c = rdy & res_rdy_2reg & (regidx_2regfile != '0);
    assign rename_act_c = rdy & rename_en & ~rollback_signal & (rename_rd != '0);
    assign bypass_ok_c  = BYPASS_EN & commit_act_c & ~rst;

    // Commit writes the value; alias clears only if the committing entry is still the
    // newest writer, and a same-cycle rename of that register overrides the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                vals[i]    <= '0;
                alias_q[i] <= '0;
            end
        end else if (rdy) begin
            if (commit_act_c) begin
                vals[regidx_2regfile] <= res_2reg;
            end
            if (rollback_signal) begin
                for (int i = 0; i < int'(NREG); i++) begin
                    alias_q[i] <= '0;
                end
            end else begin
                if (commit_act_c && (alias_q[regidx_2regfile] == reg_alias)) begin
                    alias_q[regidx_2regfile] <= '0;
                end
                if (rename_act_c) begin
                    alias_q[rename_rd] <= rename_alias;
                end
            end
        end
    end

    // Combinational source reads; x0 is hard-wired to zero value and no pending writer.
    always_comb begin
        Vi = vals[rs1_idx];
        Qi = alias_q[rs1_idx];
        Vj = vals[rs2_idx];
        Qj = alias_q[rs2_idx];
        if (bypass_ok_c && (rs1_idx == regidx_2regfile)) begin
            Vi = res_2reg;
            if (Qi == reg_alias) begin
                Qi = '0;
            end
        end
        if (bypass_ok_c && (rs2_idx == regidx_2regfile)) begin
            Vj = res_2reg;
            if (Qj == reg_alias) begin
                Qj = '0;
            end
        end
        if (rs1_idx == '0) begin
            Vi = '0;
            Qi = '0;
        end
        if (rs2_idx == '0) begin
            Vj = '0;
            Qj = '0;
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic
// against an array-based reference model of the register/alias rules.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        rollback_signal;
    logic        res_rdy_2reg;
    logic [31:0] res_2reg;
    logic [4:0]  regidx_2regfile;
    logic [4:0]  reg_alias;
    logic        rename_en;
    logic [4:0]  rename_rd;
    logic [4:0]  rename_alias;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [4:0]  Qi;
    logic [4:0]  Qj;
    logic [31:0] Vi;
    logic [31:0] Vj;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_val   [32];
    logic [4:0]  m_alias [32];

`ifdef REG_COMMIT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    reg_file dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback_signal(rollback_signal),
        .res_rdy_2reg(res_rdy_2reg), .res_2reg(res_2reg),
        .regidx_2regfile(regidx_2regfile), .reg_alias(reg_alias),
        .rename_en(rename_en), .rename_rd(rename_rd), .rename_alias(rename_alias),
        .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
        .Qi(Qi), .Qj(Qj), .Vi(Vi), .Vj(Vj)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) begin
            m_val[i]   = 32'h0;
            m_alias[i] = 5'd0;
        end
    endfunction

    function automatic bit commit_now();
        return !rst && rdy && res_rdy_2reg && (regidx_2regfile != 5'd0);
    endfunction

    function automatic logic [31:0] exp_v(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        if (BYP && commit_now() && idx == regidx_2regfile) return res_2reg;
        return m_val[idx];
    endfunction

    function automatic logic [4:0] exp_q(input logic [4:0] idx);
        if (idx == 5'd0) return 5'd0;
        if (BYP && commit_now() && idx == regidx_2regfile && m_alias[idx] == reg_alias) return 5'd0;
        return m_alias[idx];
    endfunction

    // Next-state of the architectural model for the inputs held across this edge.
    function automatic void model_edge();
        if (rst) begin
            model_clear();
        end else if (rdy) begin
            if (res_rdy_2reg && regidx_2regfile != 5'd0) begin
                m_val[regidx_2regfile] = res_2reg;
                if (!rollback_signal && m_alias[regidx_2regfile] == reg_alias)
                    m_alias[regidx_2regfile] = 5'd0;
            end
            if (rollback_signal) begin
                for (int i = 0; i < 32; i++) m_alias[i] = 5'd0;
            end else if (rename_en && rename_rd != 5'd0) begin
                m_alias[rename_rd] = rename_alias;
            end
        end
    endfunction

    task automatic check_reads(input string tag);
        check({tag, "_vi"}, Vi, exp_v(rs1_idx));
        check({tag, "_qi"}, 32'(Qi), 32'(exp_q(rs1_idx)));
        check({tag, "_vj"}, Vj, exp_v(rs2_idx));
        check({tag, "_qj"}, 32'(Qj), 32'(exp_q(rs2_idx)));
    endtask

    task automatic idle();
        rdy = 1'b1; rollback_signal = 1'b0; res_rdy_2reg = 1'b0; res_2reg = 32'h0;
        regidx_2regfile = 5'd0; reg_alias = 5'd0; rename_en = 1'b0;
        rename_rd = 5'd0; rename_alias = 5'd0;
    endtask

    // Inputs are set on the falling edge; check reads, take the rising edge, return at falling edge.
    task automatic cycle(input string tag);
        #1;
        check_reads(tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_rename(input logic [4:0] rd, input logic [4:0] al);
        idle(); rename_en = 1'b1; rename_rd = rd; rename_alias = al;
        cycle("ren");
    endtask

    task automatic set_commit(input logic [4:0] rd, input logic [4:0] al, input logic [31:0] v);
        res_rdy_2reg = 1'b1; regidx_2regfile = rd; reg_alias = al; res_2reg = v;
    endtask

    task automatic probe(input string tag, input logic [4:0] idx,
                         input logic [31:0] ev, input logic [4:0] eq);
        rs1_idx = idx;
        #1;
        check({tag, "_v"}, Vi, ev);
        check({tag, "_q"}, 32'(Qi), 32'(eq));
    endtask

    initial begin
        idle();
        rst = 1'b1; rs1_idx = 5'd0; rs2_idx = 5'd0;
        model_clear();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 32; i += 5) begin
            rs1_idx = 5'(i); rs2_idx = 5'(31 - i);
            #1;
            check("rst_vi", Vi, 32'h0); check("rst_qj", 32'(Qj), 32'h0);
        end
        rst = 1'b0;

        // Rename then commit with the matching alias clears the alias.
        do_rename(5'd5, 5'd3);
        idle(); set_commit(5'd5, 5'd3, 32'hDEADBEEF); cycle("c5");
        idle(); probe("x5", 5'd5, 32'hDEADBEEF, 5'd0);

        // Older writer commits while a newer rename is pending.
        do_rename(5'd7, 5'd3);
        do_rename(5'd7, 5'd9);
        idle(); set_commit(5'd7, 5'd3, 32'h11); cycle("c7");
        idle(); probe("x7", 5'd7, 32'h11, 5'd9);

        // x0 ignores writes and renames.
        idle(); set_commit(5'd0, 5'd4, 32'h55); rename_en = 1'b1; rename_rd = 5'd0; rename_alias = 5'd4;
        cycle("c0");
        idle(); probe("x0", 5'd0, 32'h0, 5'd0);

        // Same-cycle commit and rename of one register: rename wins the alias.
        do_rename(5'd9, 5'd4);
        idle(); set_commit(5'd9, 5'd4, 32'h77); rename_en = 1'b1; rename_rd = 5'd9; rename_alias = 5'd8;
        cycle("cr9");
        idle(); probe("x9", 5'd9, 32'h77, 5'd8);

        // Rollback with a concurrent commit and an ignored rename.
        do_rename(5'd1, 5'd2);
        do_rename(5'd2, 5'd6);
        idle(); rollback_signal = 1'b1; set_commit(5'd1, 5'd2, 32'h42);
        rename_en = 1'b1; rename_rd = 5'd3; rename_alias = 5'd7;
        cycle("rb");
        idle(); probe("rb_x1", 5'd1, 32'h42, 5'd0);
        probe("rb_x2", 5'd2, 32'h0, 5'd0);
        probe("rb_x3", 5'd3, 32'h0, 5'd0);

        // rdy low holds all state.
        idle(); rdy = 1'b0; set_commit(5'd10, 5'd0, 32'hABCD);
        rename_en = 1'b1; rename_rd = 5'd10; rename_alias = 5'd5;
        cycle("hold");
        idle(); probe("hold_x10", 5'd10, 32'h0, 5'd0);

        // Same-cycle commit read of x4 with or without bypass.
        do_rename(5'd4, 5'd5);
        idle(); set_commit(5'd4, 5'd5, 32'h99); rs1_idx = 5'd4;
        #1;
        check("byp_v", Vi, BYP ? 32'h99 : 32'h0);
        check("byp_q", 32'(Qi), BYP ? 32'h0 : 32'h5);
        @(posedge clk); model_edge(); @(negedge clk);
        idle(); probe("x4", 5'd4, 32'h99, 5'd0);

        // Asynchronous reset asserted mid-cycle clears reads before the next clock edge.
        do_rename(5'd12, 5'd11);
        idle(); set_commit(5'd12, 5'd1, 32'h1234); cycle("pre");
        idle(); rename_en = 1'b1; rename_rd = 5'd12; rename_alias = 5'd3;
        @(posedge clk); model_edge(); #2;
        rst = 1'b1; model_clear();
        rs1_idx = 5'd12; rs2_idx = 5'd12;
        #1;
        check("arst_vi", Vi, 32'h0); check("arst_qi", 32'(Qi), 32'h0);
        check("arst_vj", Vj, 32'h0); check("arst_qj", 32'(Qj), 32'h0);
        @(negedge clk);
        set_commit(5'd12, 5'd0, 32'hFFFF);
        cycle("in_rst");
        rst = 1'b0; idle();

        // Randomized traffic, occasional mid-stream reset.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(199) == 0);
            if (rst) model_clear();
            rdy = ($urandom_range(9) != 0);
            rollback_signal = ($urandom_range(19) == 0);
            res_rdy_2reg = $urandom_range(1);
            regidx_2regfile = 5'($urandom_range(31));
            res_2reg = $urandom;
            reg_alias = $urandom_range(1) ? m_alias[regidx_2regfile] : 5'($urandom_range(16, 1));
            rename_en = $urandom_range(1);
            rename_rd = ($urandom_range(3) == 0) ? regidx_2regfile : 5'($urandom_range(31));
            rename_alias = 5'($urandom_range(16, 1));
            rs1_idx = ($urandom_range(2) == 0) ? regidx_2regfile : 5'($urandom_range(31));
            rs2_idx = ($urandom_range(2) == 0) ? rename_rd : 5'($urandom_range(31));
            cycle("rnd");
        end

        rst = 1'b0; idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: rdy  input  1  global enable; low = hold all state.
REQ-004 SHALL have port: rollback_signal  input  1  mispredict flush from reorder buffer.
REQ-005 SHALL have port: res_rdy_2reg  input  1  commit strobe from reorder buffer.
REQ-006 SHALL have port: res_2reg  input  32  committed value.
REQ-007 SHALL have port: regidx_2regfile  input  5  committed destination register.
REQ-008 SHALL have port: reg_alias  input  5  reorder-buffer id of the committing entry.
REQ-009 SHALL have port: rename_en  input  1  dispatcher allocates a destination.
REQ-010 SHALL have port: rename_rd  input  5  register being renamed.
REQ-011 SHALL have port: rename_alias  input  5  new reorder-buffer id (1..16; 0 = none).
REQ-012 SHALL have port: rs1_idx, rs2_idx  input  5 each  dispatcher source queries.
REQ-013 SHALL have port: Qi, Qj  output  5 each  alias of rs1/rs2; 0 = value valid.
REQ-014 SHALL have port: Vi, Vj  output  32 each  stored value of rs1/rs2.

Function
REQ-015 SHALL hold 32 x 32-bit values and 32 x 5-bit aliases; alias 0 means no pending writer.
REQ-016 Reads (Qi/Qj/Vi/Vj) SHALL be combinational from rs1_idx/rs2_idx.
REQ-017 Register 0 SHALL always read value 0, alias 0; writes and renames to it are ignored.
REQ-018 Commit (res_rdy_2reg=1, rdy=1, rd!=0): value[rd] <= res_2reg on the next edge.
REQ-019 Commit SHALL clear alias[rd] to 0 only if alias[rd]==reg_alias; otherwise alias untouched (newer writer pending).
REQ-020 Rename (rename_en=1, rdy=1, rollback_signal=0, rd!=0): alias[rd] <= rename_alias.
REQ-021 Same cycle commit and rename of the same rd: value written, alias[rd] <= rename_alias (rename wins).
REQ-022 Rollback (rollback_signal=1, rdy=1): all aliases <= 0 on next edge; values retained; rename ignored.
REQ-023 Commit concurrent with rollback SHALL still write value[rd].
REQ-024 rdy=0: no state change; reads stay combinational.
REQ-025 Latency: commit/rename/rollback visible on reads one cycle after the edge (no bypass unless REQ-029).

Reset
REQ-026 rst=1 SHALL immediately, independent of clk, set all 32 values to 0 and all aliases to 0.
REQ-027 During reset Qi=Qj=0, Vi=Vj=0 for every index.
REQ-028 Reset release mid-stream: first edge after release processes inputs normally; reset dominates rollback, commit, rename.

Configuration
REQ-029 Macro REG_COMMIT_BYPASS_EN defined: when a commit is active this cycle and rs1/rs2 equals regidx_2regfile (!=0), Vi/Vj SHALL return res_2reg, and Qi/Qj SHALL return 0 if the stored alias equals reg_alias; not defined: reads reflect stored state only (REQ-025).
REQ-030 Bypass SHALL never apply to register 0 and SHALL not alter stored state timing.

Verification
REQ-031 Reset: assert rst mid-cycle -> all Vi/Vj/Qi/Qj read 0 immediately, before next clk.
REQ-032 Rename x5->alias 3, commit x5 val 0xDEADBEEF alias 3 -> next cycle Vi=0xDEADBEEF, Qi=0.
REQ-033 Rename x7->3, rename x7->9, commit x7 alias 3 val 0x11 -> Vi=0x11, Qi=9.
REQ-034 Commit x0 val 0x55 and rename x0->4 -> x0 reads value 0, alias 0.
REQ-035 Aliases x1=2,x2=6; rollback with commit x1 val 0x42 alias 2 -> both aliases 0, x1=0x42; concurrent rename x3->7 ignored.
REQ-036 With REG_COMMIT_BYPASS_EN: x4 alias 5, commit x4 val 0x99 alias 5, query rs1=4 same cycle -> Vi=0x99, Qi=0; without macro -> Vi old, Qi=5 that cycle.
